// File: rtl/event_pkg.sv
// Shared types and defaults for the event merger: FSM states, default sizing and the
// two-bit source mask ({B,A}).
package event_pkg;

  typedef enum logic {StIdle, StHold} state_e;

  localparam int unsigned DefHoldoff = 10;
  localparam int unsigned DefCntW    = 8;

  typedef logic [1:0] src_mask_t;

  // Number of set bits in a source mask (0..2).
  function automatic logic [1:0] mask_pop(src_mask_t m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/event_merge_if.sv
// Event merger signal bundle: the master side drives enable and event levels, the slave side
// (the merger) returns the trigger strobe, source mask, busy flag and counters.
interface event_merge_if #(
  parameter int unsigned CNT_W = event_pkg::DefCntW
);
  import event_pkg::*;

  logic             en;
  logic             ev_a;
  logic             ev_b;
  logic             trig;
  src_mask_t        src;
  logic             busy;
  logic [CNT_W-1:0] trig_cnt;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output en, ev_a, ev_b,
    input  trig, src, busy, trig_cnt, drop_cnt
  );

  modport slave (
    input  en, ev_a, ev_b,
    output trig, src, busy, trig_cnt, drop_cnt
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for one synchronous level input. The history flop tracks the input
// during reset so a level held high across reset release is not seen as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  assign prev_d = level_i;
  assign rise_o = level_i & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= level_i;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/event_merge.sv
// Merges two event sources into one rate-limited trigger strobe; edges arriving during the
// hold window are collected and issued together when the window expires.
module event_merge
  import event_pkg::*;
#(
  parameter int unsigned HOLDOFF = DefHoldoff,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic         clk,
  input  logic         rst,
  event_merge_if.slave bus
);

  localparam logic [7:0] Reload = 8'(HOLDOFF - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  src_mask_t        pend_q, pend_d;
  logic             trig_q, trig_d;
  src_mask_t        src_q, src_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             rise_a, rise_b;
  src_mask_t        acc;
  src_mask_t        fire;
  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;

  edge_detect u_edge_a (
    .clk     (clk),
    .rst     (rst),
    .level_i (bus.ev_a),
    .rise_o  (rise_a)
  );

  edge_detect u_edge_b (
    .clk     (clk),
    .rst     (rst),
    .level_i (bus.ev_b),
    .rise_o  (rise_b)
  );

  assign acc = {rise_b, rise_a} & {2{bus.en}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    trig_d   = 1'b0;
    src_d    = '0;
    drop_inc = '0;
    fire     = '0;
    unique case (state_q)
      StIdle: begin
        if (acc != '0) begin
          trig_d  = 1'b1;
          src_d   = acc;
          cnt_d   = Reload;
          state_d = StHold;
        end
      end
      StHold: begin
        // A repeat edge on a source that is already pending is lost.
        drop_inc = mask_pop(acc & pend_q);
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 8'd1;
          pend_d = pend_q | acc;
        end else begin
          fire   = pend_q | acc;
          pend_d = '0;
          if (fire != '0) begin
            trig_d = 1'b1;
            src_d  = fire;
            cnt_d  = Reload;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    trig_cnt_d = trig_cnt_q + CNT_W'(trig_d);
    drop_sum   = {1'b0, drop_cnt_q} + (CNT_W + 1)'(drop_inc);
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pend_q     <= '0;
      trig_q     <= 1'b0;
      src_q      <= '0;
      trig_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      trig_q     <= trig_d;
      src_q      <= src_d;
      trig_cnt_q <= trig_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.trig     = trig_q;
  assign bus.src      = src_q;
  assign bus.busy     = (state_q == StHold);
  assign bus.trig_cnt = trig_cnt_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_event_merge.sv
// Bench for event_merge: a time-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_event_merge;

  localparam int unsigned Holdoff = 10;
  localparam int unsigned CntW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  event_merge_if #(.CNT_W(CntW)) bus ();

  event_merge #(
    .HOLDOFF (Holdoff),
    .CNT_W   (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: hold window measured in absolute cycles since the last trigger.
  int       cyc    = 0;
  int       last_t = -1000;
  bit       m_busy = 0;
  bit [1:0] m_pend = 0;
  bit       m_trig = 0;
  bit [1:0] m_src  = 0;
  int       m_tcnt = 0;
  int       m_dcnt = 0;
  bit       pa = 0, pb = 0;
  bit [1:0] acc;

  task automatic fire(input bit [1:0] mask);
    m_trig = 1;
    m_src  = mask;
    last_t = cyc;
    m_busy = 1;
    m_tcnt = (m_tcnt + 1) % (1 << CntW);
  endtask

  always @(posedge clk) begin
    cyc++;
    m_trig = 0;
    m_src  = 0;
    if (rst) begin
      m_busy = 0;
      m_pend = 0;
      m_tcnt = 0;
      m_dcnt = 0;
      pa     = bus.ev_a;
      pb     = bus.ev_b;
    end else begin
      acc = {bus.ev_b && !pb, bus.ev_a && !pa} & {2{bus.en}};
      pa  = bus.ev_a;
      pb  = bus.ev_b;
      if (!m_busy) begin
        if (acc != 0) fire(acc);
      end else begin
        for (int s = 0; s < 2; s++)
          if (acc[s] && m_pend[s] && m_dcnt < (1 << CntW) - 1) m_dcnt++;
        m_pend |= acc;
        if (cyc - last_t == Holdoff) begin
          if (m_pend != 0) fire(m_pend);
          else m_busy = 0;
          m_pend = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, plus trigger spacing measured on the DUT itself.
  bit chk_en      = 0;
  bit strict_gap  = 0;
  int last_dut_t  = -1000;

  always @(negedge clk) begin
    if (chk_en) begin
      check("trig", 32'(bus.trig), 32'(m_trig));
      check("src", 32'(bus.src), 32'(m_src));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("trig_cnt", 32'(bus.trig_cnt), 32'(m_tcnt));
      check("drop_cnt", 32'(bus.drop_cnt), 32'(m_dcnt));
      if (rst) begin
        last_dut_t = -1000;
      end else if (bus.trig === 1'b1) begin
        if (last_dut_t > 0) begin
          if (strict_gap) check("trig_gap", 32'(cyc - last_dut_t), 32'(Holdoff));
          else check("trig_gap_min", 32'(cyc - last_dut_t >= int'(Holdoff)), 32'd1);
        end
        last_dut_t = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two reset edges; afterwards the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    bus.en   = 1'b1;
    bus.ev_a = 1'b0;
    bus.ev_b = 1'b0;
    do_reset();
    chk_en = 1;
    check("rst_trig_cnt", 32'(bus.trig_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single A edge at edge 5.
    idle(4);
    bus.ev_a = 1'b1;
    idle(1);
    check("a_trig", 32'(bus.trig), 32'd1);
    check("a_src", 32'(bus.src), 32'd1);
    check("a_busy", 32'(bus.busy), 32'd1);
    check("a_trig_cnt", 32'(bus.trig_cnt), 32'd1);

    // A at 5, B at 8, B re-rises at 10 -> drop, second trig at 15 with src=10.
    bus.ev_a = 1'b0;
    idle(15);
    do_reset();
    idle(4);
    bus.ev_a = 1'b1;
    idle(1);
    idle(2);
    bus.ev_b = 1'b1;
    idle(1);
    bus.ev_b = 1'b0;
    idle(1);
    bus.ev_b = 1'b1;
    idle(5);
    check("ab_gap_quiet", 32'(bus.trig), 32'd0);
    idle(1);
    check("ab_trig2", 32'(bus.trig), 32'd1);
    check("ab_src2", 32'(bus.src), 32'd2);
    check("ab_drop", 32'(bus.drop_cnt), 32'd1);
    check("ab_trig_cnt", 32'(bus.trig_cnt), 32'd2);
    idle(10);
    check("ab_back_idle", 32'(bus.busy), 32'd0);

    // Simultaneous A and B at edge 3.
    bus.ev_a = 1'b0;
    bus.ev_b = 1'b0;
    do_reset();
    idle(2);
    bus.ev_a = 1'b1;
    bus.ev_b = 1'b1;
    idle(1);
    check("both_trig", 32'(bus.trig), 32'd1);
    check("both_src", 32'(bus.src), 32'd3);
    check("both_trig_cnt", 32'(bus.trig_cnt), 32'd1);
    check("both_drop", 32'(bus.drop_cnt), 32'd0);
    idle(1);
    check("both_single", 32'(bus.trig), 32'd0);

    // A toggling every 2 cycles: drops saturate, triggers every Holdoff cycles.
    bus.ev_a = 1'b0;
    bus.ev_b = 1'b0;
    do_reset();
    strict_gap = 1;
    for (int i = 0; i < 750; i++) begin
      bus.ev_a = 1'b1;
      idle(2);
      bus.ev_a = 1'b0;
      idle(2);
    end
    check("sat_drop", 32'(bus.drop_cnt), 32'd255);
    strict_gap = 0;

    // B held high across reset release: no event.
    bus.ev_b = 1'b1;
    do_reset();
    idle(12);
    check("held_b_trig_cnt", 32'(bus.trig_cnt), 32'd0);
    check("held_b_busy", 32'(bus.busy), 32'd0);

    // Reset mid-hold with A pending: everything clears, no later trigger.
    bus.ev_b = 1'b0;
    do_reset();
    bus.ev_b = 1'b1;
    idle(2);
    bus.ev_a = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(1);
    check("midrst_trig", 32'(bus.trig), 32'd0);
    check("midrst_src", 32'(bus.src), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_trig_cnt", 32'(bus.trig_cnt), 32'd0);
    check("midrst_drop", 32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;
    idle(20);
    check("midrst_no_trig", 32'(bus.trig_cnt), 32'd0);

    // en=0 while A rises: ignored, and no edge once en returns with A still high.
    bus.ev_a = 1'b0;
    bus.ev_b = 1'b0;
    bus.en   = 1'b0;
    do_reset();
    idle(2);
    bus.ev_a = 1'b1;
    idle(5);
    bus.en = 1'b1;
    idle(5);
    check("en0_trig_cnt", 32'(bus.trig_cnt), 32'd0);
    check("en0_drop", 32'(bus.drop_cnt), 32'd0);
    check("en0_busy", 32'(bus.busy), 32'd0);

    // en dropped during hold with B pending: trigger still issued at edge 13.
    bus.ev_a = 1'b0;
    do_reset();
    idle(2);
    bus.ev_a = 1'b1;
    idle(1);
    bus.ev_b = 1'b1;
    idle(1);
    bus.en = 1'b0;
    idle(9);
    check("en0_hold_trig", 32'(bus.trig), 32'd1);
    check("en0_hold_src", 32'(bus.src), 32'd2);
    check("en0_hold_trig_cnt", 32'(bus.trig_cnt), 32'd2);
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/event_merge.md
EVENT_MERGE -- requirements
Module: event_merge

Interface
REQ-001 Parameter HOLDOFF, default 10, minimum trigger spacing in clk cycles (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, width of trig_cnt and drop_cnt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  1 = accept source edges; 0 = ignore all new edges.
REQ-006 ev_a  input  1  event source A, level, already synchronous to clk.
REQ-007 ev_b  input  1  event source B, level, already synchronous to clk.
REQ-008 trig  output  1  merged event strobe, one-cycle pulse, registered; feeds the downstream fork/compute stage.
REQ-009 src  output  2  source mask for the current trig ({B,A}); valid only while trig=1, else 0.
REQ-010 busy  output  1  1 while in the HOLD state.
REQ-011 trig_cnt  output  CNT_W  count of trig pulses issued; wraps.
REQ-012 drop_cnt  output  CNT_W  count of discarded edges; saturates at all-ones.

Function
REQ-013 Rising edge of ev_x = ev_x high at clock edge n and low at edge n-1; only rising edges are events; edges with en=0 are discarded silently (no count).
REQ-014 States: IDLE, HOLD; enumeration lives in the shared package.
REQ-015 IDLE: any accepted edge at clock edge n -> trig=1 for the cycle after edge n, src = mask of sources with edges, state -> HOLD, hold counter loaded with HOLDOFF-1.
REQ-016 Simultaneous A and B edges in one cycle -> exactly one trig, src=2'b11.
REQ-017 HOLD: counter decrements each cycle; accepted edges OR into pending[1:0].
REQ-018 Edge on source x while pending[x] already 1 -> drop_cnt += 1 per source (A and B both dropped same cycle -> +2, saturating).
REQ-019 At the edge where the counter reaches 0: if (pending | current accepted edges) != 0 -> trig=1 next cycle with src = that mask, pending cleared, counter reloaded, stay HOLD; else -> IDLE, busy=0.
REQ-020 Consequence: consecutive trig pulses are never closer than HOLDOFF cycles; trig is never high on two adjacent cycles.
REQ-021 trig_cnt increments in the same cycle trig is high; wraps from all-ones to 0.
REQ-022 en deassertion does not cancel pending bits or the hold counter; a pending edge still issues trig at hold expiry.
REQ-023 A level held high produces one event only; no retrigger until it falls and rises again.

Reset
REQ-024 rst=1 at a clock edge: state=IDLE, trig=0, src=0, busy=0, pending=0, counter=0, trig_cnt=0, drop_cnt=0.
REQ-025 During rst the edge-detect history registers load the current ev_a/ev_b values, so an input held high across reset release produces no edge.
REQ-026 rst mid-HOLD discards pending events without counting them as drops; first trig after release requires a fresh edge.

Structure
REQ-027 Package event_pkg holds the state enum, default HOLDOFF, default CNT_W and the 2-bit source-mask type.
REQ-028 One sub-module, edge_detect (per-source rising-edge detector with reset preload), instantiated twice.

Verification (HOLDOFF=10, CNT_W=8, en=1 unless stated)
REQ-029 ev_a rises at edge 5 -> trig=1, src=01 in cycle after edge 5; busy=1; trig_cnt=1.
REQ-030 ev_a rises at 5, ev_b rises at 8, ev_b falls at 9 and rises again at 10 -> second trig 10 cycles after first, src=10; drop_cnt=1.
REQ-031 ev_a and ev_b rise together at edge 3 -> single trig, src=11, trig_cnt=1, drop_cnt=0.
REQ-032 Toggle ev_a every 2 cycles for 3000 cycles -> drop_cnt saturates at 255, never wraps; trig spacing always 10.
REQ-033 ev_b held high through rst release -> no trig; rst asserted mid-HOLD with pending=01 -> all outputs 0 next cycle, no later trig.
REQ-034 en=0 while ev_a rises -> no trig, counters unchanged; en=0 during HOLD with pending set -> trig still issued at expiry.
